quad_decoder: RTL

//  Decodes a 2-phase quadrature input (A/B) into single-cycle step strobes (en)

---
 rtl/quad_pkg.sv | 57 +++++
 rtl/quad_sync_filter.sv | 72 +++++++
 rtl/quad_decoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared encodings and step decode for the quadrature decoder.
// Phase pairs are written {A,B}; the forward (up) Gray order is 00 -> 10 -> 11 -> 01.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } step_t;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } prime_state_t;

  function automatic logic [1:0] next_fwd(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // Any change that is neither a forward nor a reverse neighbour flips both
  // phases at once and cannot be attributed to a direction.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t r;
    r = '0;
    if (cur == prev) begin
      r = '0;
    end else if (cur == next_fwd(prev)) begin
      r.valid = 1'b1;
      r.up    = 1'b1;
    end else if (cur == next_rev(prev)) begin
      r.valid = 1'b1;
    end else begin
      r.illegal = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Per-phase 2-FF synchronizer with an optional persistence filter.
// Filter is built only when QUAD_FILTER_EN is defined; o_valid marks real data after reset.
module quad_sync_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_out,
  output logic o_valid
);

  logic       r_meta;
  logic       r_sync;
  logic [1:0] r_vld_pipe;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta     <= 1'b0;
      r_sync     <= 1'b0;
      r_vld_pipe <= 2'b00;
    end else begin
      r_meta     <= i_in;
      r_sync     <= r_meta;
      r_vld_pipe <= {r_vld_pipe[0], 1'b1};
    end
  end

`ifdef QUAD_FILTER_EN
  localparam int CW = ($clog2(FILT_LEN) > 0) ? $clog2(FILT_LEN) : 1;

  logic          r_filt;
  logic          r_filt_vld;
  logic [CW-1:0] r_cnt;

  // The first real sample seeds the filter so a level held through reset is
  // not reported later as a transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt     <= 1'b0;
      r_filt_vld <= 1'b0;
      r_cnt      <= '0;
    end else if (!r_filt_vld) begin
      r_cnt <= '0;
      if (r_vld_pipe[1]) begin
        r_filt     <= r_sync;
        r_filt_vld <= 1'b1;
      end
    end else if (r_sync == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(FILT_LEN - 1)) begin
      r_filt <= r_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_out   = r_filt;
  assign o_valid = r_filt_vld;
`else
  // Unfiltered build: the length parameter has no hardware to size.
  if (FILT_LEN < 1) begin : g_filt_len_unused
  end

  assign o_out   = r_sync;
  assign o_valid = r_vld_pipe[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: step strobe + direction, saturating position, illegal-step flags.
// Define QUAD_FILTER_EN to insert a FILT_LEN-sample glitch filter after the synchronizers.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic             en,
  output logic             up,
  output logic [WIDTH-1:0] pos,
  output logic             err,
  output logic             err_sticky
);

  localparam logic [WIDTH-1:0] POS_MAX = '1;

  logic       w_a;
  logic       w_b;
  logic       w_a_vld;
  logic       w_b_vld;
  logic [1:0] w_s;
  step_t      w_step;

  prime_state_t     r_state;
  logic [1:0]       r_prev;
  logic             r_en;
  logic             r_up;
  logic             r_err;
  logic             r_err_sticky;
  logic [WIDTH-1:0] r_pos;

  quad_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_a (
    .clk     (clk),
    .rst     (rst),
    .i_in    (a_in),
    .o_out   (w_a),
    .o_valid (w_a_vld)
  );

  quad_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_b (
    .clk     (clk),
    .rst     (rst),
    .i_in    (b_in),
    .o_out   (w_b),
    .o_valid (w_b_vld)
  );

  assign w_s    = {w_a, w_b};
  assign w_step = decode_step(r_prev, w_s);

  // Priming waits until the synchronizers carry real samples, so the zeros
  // they hold out of reset are never compared against the true pin levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_PRIME;
      r_prev       <= PH_00;
      r_en         <= 1'b0;
      r_up         <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_pos        <= '0;
    end else begin
      r_en   <= 1'b0;
      r_err  <= 1'b0;
      r_prev <= w_s;

      case (r_state)
        ST_PRIME: begin
          if (w_a_vld && w_b_vld) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_step.valid) begin
            r_en <= 1'b1;
            r_up <= w_step.up;
          end
          if (w_step.illegal) r_err <= 1'b1;
        end
        default: r_state <= ST_PRIME;
      endcase

      // Clear beats any same-edge step or error for the held state only;
      // the strobes above still report what the pins did.
      if (clr) begin
        r_pos        <= '0;
        r_err_sticky <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (w_step.valid) begin
          if (w_step.up && (r_pos != POS_MAX)) r_pos <= r_pos + WIDTH'(1);
          else if (!w_step.up && (r_pos != '0)) r_pos <= r_pos - WIDTH'(1);
        end
        if (w_step.illegal) r_err_sticky <= 1'b1;
      end
    end
  end

  assign en         = r_en;
  assign up         = r_up;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign pos        = r_pos;

endmodule
